// File: rtl/andnot_sweep_ctrl.sv
// Sweep sequencer for the z = a & ~b gate: drives all four {a,b} vectors for a
// programmable number of sweeps, checks z after a settle interval, reports a verdict.
module andnot_sweep_ctrl #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned SWEEPS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       z_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [1:0] fail_vec,
  output logic       fail_valid,
  output logic [1:0] vec_idx
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SWP_W = 8;
  localparam int unsigned ERR_W = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_APPLY = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE);
  localparam logic [SWP_W-1:0] LAST_SWEEP = SWP_W'(SWEEPS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SWP_W-1:0] sweep_q, sweep_d;
  logic [1:0]       vec_q, vec_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [1:0]       fvec_q, fvec_d;
  logic             fvalid_q, fvalid_d;

  logic             mismatch;
  logic [ERR_W-1:0] err_inc;

  // Reference value is taken from the vector index, not from the driven pins
  assign mismatch = z_in != (vec_q[1] & ~vec_q[0]);
  assign err_inc  = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sweep_q  <= '0;
      vec_q    <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fvec_q   <= '0;
      fvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sweep_q  <= sweep_d;
      vec_q    <= vec_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fvec_q   <= fvec_d;
      fvalid_q <= fvalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_d  = sweep_q;
    vec_d    = vec_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fvec_d   = fvec_q;
    fvalid_d = fvalid_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_APPLY;
          sweep_d  = '0;
          vec_d    = '0;
          err_d    = '0;
          fvec_d   = '0;
          fvalid_d = 1'b0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
        end
      end
      S_APPLY: begin
        a_d     = vec_q[1];
        b_d     = vec_q[0];
        cnt_d   = SETTLE_LD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          err_d = err_inc;
          if (!fvalid_q) begin
            fvec_d   = vec_q;
            fvalid_d = 1'b1;
          end
        end
        if (vec_q != 2'd3) begin
          vec_d   = vec_q + 2'd1;
          state_d = S_APPLY;
        end else if (sweep_q == LAST_SWEEP) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          sweep_d = sweep_q + SWP_W'(1);
          vec_d   = 2'd0;
          state_d = S_APPLY;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_vec   = fvec_q;
  assign fail_valid = fvalid_q;
  assign vec_idx    = vec_q;

endmodule

// File: tb/tb_andnot_sweep_ctrl.sv
// Scoreboard bench for andnot_sweep_ctrl: a truth-table gate model feeds z_in,
// expected run results come from a sweep-level reference model.
module tb_andnot_sweep_ctrl;

  localparam int unsigned SETTLE     = 1;
  localparam int unsigned SWEEPS     = 2;
  localparam int unsigned SAT_SWEEPS = 100;

  logic       clk = 1'b0;
  logic       reset, start, start_sat, z_in;
  logic [3:0] tt;
  logic       a_out, b_out, busy, done, pass, fail_valid;
  logic [7:0] err_count;
  logic [1:0] fail_vec, vec_idx;
  logic       s_a, s_b, s_busy, s_done, s_pass, s_fvalid;
  logic [7:0] s_err;
  logic [1:0] s_fvec, s_vec;

  always #5 clk = ~clk;

  // Gate under test modelled as a truth table indexed by {a,b}
  assign z_in = tt[{a_out, b_out}];

  andnot_sweep_ctrl #(.SETTLE(SETTLE), .SWEEPS(SWEEPS)) dut (
    .clk(clk), .reset(reset), .start(start), .z_in(z_in),
    .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec), .fail_valid(fail_valid),
    .vec_idx(vec_idx)
  );

  andnot_sweep_ctrl #(.SETTLE(SETTLE), .SWEEPS(SAT_SWEEPS)) dut_sat (
    .clk(clk), .reset(reset), .start(start_sat), .z_in(1'b1),
    .a_out(s_a), .b_out(s_b), .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_count(s_err), .fail_vec(s_fvec), .fail_valid(s_fvalid),
    .vec_idx(s_vec)
  );

  typedef struct {
    int err;
    int fvec;
    int fvalid;
    int pass;
    int len;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Whole-run result computed from the gate truth table
  function automatic exp_t model(input logic [3:0] tt_v, input int sweeps, input int settle);
    exp_t e;
    int   errs = 0;
    int   first = -1;
    for (int s = 0; s < sweeps; s++) begin
      for (int v = 0; v < 4; v++) begin
        if (int'(tt_v[v]) != ((v == 2) ? 1 : 0)) begin
          errs++;
          if (first < 0) first = v;
        end
      end
    end
    e.err    = (errs > 255) ? 255 : errs;
    e.fvec   = (first < 0) ? 0 : first;
    e.fvalid = (first < 0) ? 0 : 1;
    e.pass   = (errs == 0) ? 1 : 0;
    e.len    = 4 * sweeps * (settle + 2);
    return e;
  endfunction

  // Monitor: track each run from busy rising, check vectors, score on done
  bit in_run = 1'b0;
  int k = 0;
  always @(negedge clk) begin
    exp_t e;
    int   j;
    if (!reset) chk("busy_done_excl", int'(busy & done), 0);
    if (!in_run) begin
      if (busy) begin
        in_run = 1'b1;
        k = 0;
      end
    end else begin
      k++;
    end
    if (in_run) begin
      if (done) begin
        in_run = 1'b0;
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_empty: done seen with no expected run (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          chk("run_len", k, e.len);
          chk("err_count", int'(err_count), e.err);
          chk("fail_vec", int'(fail_vec), e.fvec);
          chk("fail_valid", int'(fail_valid), e.fvalid);
          chk("pass", int'(pass), e.pass);
        end
      end else if (!busy) begin
        in_run = 1'b0;
      end else if ((k % (SETTLE + 2)) == (SETTLE + 1)) begin
        j = (k / (SETTLE + 2)) % 4;
        chk("vec_ab", int'({a_out, b_out}), j);
        chk("vec_idx", int'(vec_idx), j);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_a"}, int'(a_out), 0);
    chk({tag, "_b"}, int'(b_out), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_err"}, int'(err_count), 0);
    chk({tag, "_fvec"}, int'(fail_vec), 0);
    chk({tag, "_fvalid"}, int'(fail_valid), 0);
    chk({tag, "_vec"}, int'(vec_idx), 0);
  endtask

  // poke: 0 = no start during run, 1 = start held while busy, 2 = random start pulses
  task automatic do_run(input logic [3:0] tt_v, input int poke);
    int cyc;
    tt = tt_v;
    sb_q.push_back(model(tt_v, SWEEPS, SETTLE));
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      if (poke == 1) start = busy;
      else if (poke == 2) start = busy && ($urandom_range(0, 1) == 1);
      else start = 1'b0;
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("run_done_seen", int'(done), 1);
    tick();
  endtask

  initial begin
    int cyc;
    exp_t e;
    reset     = 1'b1;
    start     = 1'b0;
    start_sat = 1'b0;
    tt        = 4'b0100;
    tick();
    tick();
    check_reset("rst");
    reset = 1'b0;
    tick();

    // Directed: correct gate, stuck-at-1, a&b fault, start held through the run
    do_run(4'b0100, 0);
    do_run(4'b1111, 0);
    do_run(4'b1000, 0);
    do_run(4'b0100, 1);

    // Start held high: back-to-back runs with a one-cycle done between them
    tt = 4'b0100;
    sb_q.push_back(model(tt, SWEEPS, SETTLE));
    sb_q.push_back(model(tt, SWEEPS, SETTLE));
    start = 1'b1;
    tick();
    cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("held_done", int'(done), 1);
    tick();
    chk("held_done_1cyc", int'(done), 0);
    chk("held_busy", int'(busy), 1);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("held_done2", int'(done), 1);
    tick();

    // Reset during WAIT of vector 10 in sweep 1, then a clean run
    tt = 4'b1111;
    sb_q.push_back(model(tt, SWEEPS, SETTLE));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    chk("pre_reset_err", int'(err_count), 5);
    chk("pre_reset_vec", int'(vec_idx), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete();
    check_reset("midrst");
    do_run(4'b0100, 0);

    // Random gate faults with random start activity and idle gaps
    repeat (10) begin
      repeat ($urandom_range(0, 3)) tick();
      do_run(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
    end

    // Saturation on the long-run instance
    e = model(4'b1111, SAT_SWEEPS, SETTLE);
    start_sat = 1'b1;
    tick();
    start_sat = 1'b0;
    cyc = 0;
    while (!s_done && cyc < 1500) begin
      tick();
      cyc++;
    end
    chk("sat_len", cyc, e.len);
    chk("sat_err", int'(s_err), e.err);
    chk("sat_fvec", int'(s_fvec), e.fvec);
    chk("sat_fvalid", int'(s_fvalid), e.fvalid);
    chk("sat_pass", int'(s_pass), e.pass);
    chk("sat_busy", int'(s_busy), 0);
    tick();
    chk("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
